// File: rtl/cpu10_pkg.sv
// -----------------------------------------------------------------------------
// cpu10_pkg
//
// Shared widths and types for the 10-bit CPU. Fetch, decode and execute all
// agree on these, so the prefetch queue takes its parameter defaults from here.
//
// Contents:
//   ADDR_W     - PC / instruction ROM address width
//   INSTR_W    - instruction word width
//   RESET_PC   - first fetch address after reset
//   IQ_DEPTH   - default prefetch queue depth (power of two, >= 2)
//   iq_entry_t - one prefetch queue entry: {instr, pc}
// -----------------------------------------------------------------------------
package cpu10_pkg;

   localparam int                ADDR_W   = 10;
   localparam int                INSTR_W  = 10;
   localparam logic [ADDR_W-1:0] RESET_PC = 10'd0;
   localparam int                IQ_DEPTH = 4;

   // Instruction together with the PC it was fetched from. The instruction
   // occupies the upper bits so a flat {instr, pc} vector has the same layout.
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } iq_entry_t;

endpackage

// File: rtl/iq_fifo.sv
// -----------------------------------------------------------------------------
// iq_fifo
//
// Synchronous FIFO used as the instruction queue of the prefetch stage.
// Storage is a small register array; the head entry is read combinationally
// so the consumer sees it in the same cycle it becomes valid.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset; clears pointers, count and
//                   the storage itself (so an invalid head reads as 0)
//   flush      in   drop every entry this cycle; wins over push and pop
//   push       in   write push_data at the tail
//   push_data  in   entry to write
//   pop        in   advance the head (ignored while empty)
//   head       out  entry at the head (meaningless while count == 0)
//   count      out  number of entries held, 0..DEPTH
//
// Parameters:
//   W      entry width
//   DEPTH  number of entries; must be a power of two and at least 2 so the
//          pointers can wrap naturally at their bit width
// -----------------------------------------------------------------------------
module iq_fifo #(
   parameter  int W     = 20,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [W-1:0]     push_data,
   input  logic             pop,
   output logic [W-1:0]     head,
   output logic [CNT_W-1:0] count
);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] cnt;
   logic             full;
   logic             empty;
   logic             do_pop;

   assign full   = (cnt == CNT_W'(DEPTH));
   assign empty  = (cnt == '0);
   assign do_pop = pop && !empty;

   assign head  = mem[rd_ptr];
   assign count = cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         // Storage is left as-is: stale words are unreachable once count is 0.
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, do_pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // The producer's credit scheme must never let a push land on a full queue.
   a_no_push_when_full: assert property (
      @(posedge clk) disable iff (rst) !(push && !flush && full)
   );

endmodule

// File: rtl/instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue
//
// Prefetch stage of the 10-bit CPU. Owns the fetch PC, issues reads to the
// synchronous instruction ROM (data returns one cycle after the request) and
// buffers returned {instr, pc} pairs in iq_fifo for decode/execute.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   halt         in   level; blocks new ROM requests only
//   redirect     in   one-cycle pulse from execute (taken branch / jump)
//   redirect_pc  in   target PC, valid with redirect
//   rom_req      out  ROM read enable this cycle
//   rom_addr     out  ROM read address
//   rom_data     in   ROM read data, one cycle after rom_req
//   instr_valid  out  queue head is valid
//   instr_out    out  instruction at the head
//   instr_pc     out  PC of instr_out
//   instr_ready  in   consumer takes the head this cycle
//   occupancy    out  entries currently queued
//
// Handshake: the head transfers on a cycle where instr_valid && instr_ready
// are both high at the rising edge, except in a redirect cycle, where the
// queue is flushed and the transfer does not happen (the consumer must
// discard it). instr_valid never depends on instr_ready.
//
// Credits: a request is only issued when the entries that will be left after
// this cycle's pop, plus the response still in flight, leave room for one
// more. That bounds queued + in-flight at DEPTH, so a returning response
// always finds a free slot and no response ever has to be dropped for space.
// -----------------------------------------------------------------------------
module instr_prefetch_queue #(
   parameter int                ADDR_W   = cpu10_pkg::ADDR_W,
   parameter int                INSTR_W  = cpu10_pkg::INSTR_W,
   parameter int                DEPTH    = cpu10_pkg::IQ_DEPTH,
   parameter logic [ADDR_W-1:0] RESET_PC = cpu10_pkg::RESET_PC
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     halt,
   input  logic                     redirect,
   input  logic [ADDR_W-1:0]        redirect_pc,
   output logic                     rom_req,
   output logic [ADDR_W-1:0]        rom_addr,
   input  logic [INSTR_W-1:0]       rom_data,
   output logic                     instr_valid,
   output logic [INSTR_W-1:0]       instr_out,
   output logic [ADDR_W-1:0]        instr_pc,
   input  logic                     instr_ready,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int EW    = INSTR_W + ADDR_W;

   // Fetch-side state
   logic [ADDR_W-1:0] fpc;
   logic              inflight;
   logic [ADDR_W-1:0] inflight_pc;

   // Queue interface
   logic [CNT_W-1:0]  fifo_count;
   logic [EW-1:0]     fifo_head;
   logic              push;
   logic              pop;

   // Credit computation
   logic [CNT_W-1:0]  count_eff;
   logic              inflight_eff;
   logic [CNT_W:0]    credit_used;

   // ---------------------------------------------------------------------
   // Consumer side
   // ---------------------------------------------------------------------
   // Outputs are forced quiet while rst is high so the reset cycle itself
   // presents an empty, idle stage even before the first reset edge.
   assign instr_valid = !rst && (fifo_count != '0);
   assign instr_out   = fifo_head[EW-1:ADDR_W];
   assign instr_pc    = fifo_head[ADDR_W-1:0];
   assign occupancy   = rst ? '0 : fifo_count;

   // A redirect flushes the queue, so a same-cycle handshake is void.
   assign pop  = instr_valid && instr_ready && !redirect;

   // The in-flight response belongs to the old path when redirecting.
   assign push = inflight && !redirect;

   // ---------------------------------------------------------------------
   // Issue / credit logic
   // ---------------------------------------------------------------------
   always_comb begin
      count_eff    = '0;
      inflight_eff = 1'b0;
      if (!redirect) begin
         count_eff    = fifo_count - CNT_W'(pop);
         inflight_eff = inflight;
      end
   end

   assign credit_used = {1'b0, count_eff} + (CNT_W + 1)'(inflight_eff);

   assign rom_req  = !rst && !halt && (credit_used < (CNT_W + 1)'(DEPTH));
   assign rom_addr = redirect ? redirect_pc : fpc;

   // ---------------------------------------------------------------------
   // Fetch PC and in-flight tracking
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         fpc         <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         inflight <= rom_req;
         if (rom_req) begin
            inflight_pc <= rom_addr;
            fpc         <= rom_addr + ADDR_W'(1);   // wraps at 2^ADDR_W
         end else if (redirect) begin
            // Halted redirect: remember the target so issue resumes there.
            fpc <= redirect_pc;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Instruction queue
   // ---------------------------------------------------------------------
   iq_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_iq_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect),
      .push      (push),
      .push_data ({rom_data, inflight_pc}),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

endmodule
